// File: rtl/dsp_voice_envelope.sv
// rtl/dsp_voice_envelope.sv - per-voice ADSR envelope, sample gain and stereo volume stage
// Optional output saturation: define DSP_ENV_SATURATE_EN (otherwise the volume stage wraps).
module dsp_voice_envelope #(
    parameter logic [10:0] ENV_MAX     = 11'h7FF,
    parameter int          RELEASE_DEC = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sample_tick,
    input  logic signed [15:0] sample_in,
    input  logic               voice_end,
    input  logic               key_on,
    input  logic               key_off,
    input  logic        [3:0]  attack_rate,
    input  logic        [2:0]  decay_rate,
    input  logic        [2:0]  sustain_level,
    input  logic        [4:0]  sustain_rate,
    input  logic signed [7:0]  volume_left,
    input  logic signed [7:0]  volume_right,
    output logic signed [15:0] out_left,
    output logic signed [15:0] out_right,
    output logic               out_valid,
    output logic        [10:0] envelope,
    output logic        [2:0]  env_state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    localparam logic signed [11:0] REL_DEC = 12'(RELEASE_DEC);

    state_t             r_state;
    logic        [10:0] r_env;
    logic        [4:0]  r_cnt;
    logic               r_v1;
    logic signed [15:0] r_s1;
    logic signed [15:0] r_out_l;
    logic signed [15:0] r_out_r;
    logic               r_out_v;

    logic signed [11:0] w_env_s;
    logic signed [11:0] w_exp_dec;
    logic signed [11:0] w_exp_res;
    logic        [10:0] w_exp_env;
    logic        [11:0] w_att_sum;
    logic signed [11:0] w_rel_res;
    logic        [11:0] w_sus_thr;
    logic        [4:0]  w_period_m1;
    logic               w_fire;
    logic signed [27:0] w_prod1;
    logic signed [23:0] w_prod_l;
    logic signed [23:0] w_prod_r;

    assign w_env_s   = signed'({1'b0, r_env});
    // Exponential decay: subtract roughly 1/256 of the level, at least 1 while nonzero.
    assign w_exp_dec = ((w_env_s - 12'sd1) >>> 8) + 12'sd1;
    assign w_exp_res = w_env_s - w_exp_dec;
    assign w_exp_env = (w_exp_res < 12'sd0) ? 11'd0 : w_exp_res[10:0];
    assign w_att_sum = {1'b0, r_env} + ((attack_rate == 4'd15) ? 12'd1024 : 12'd32);
    assign w_rel_res = w_env_s - REL_DEC;
    assign w_sus_thr = {({1'b0, sustain_level} + 4'd1), 8'h00};

    always_comb begin
        w_period_m1 = 5'd0;
        case (r_state)
            ST_ATTACK:  w_period_m1 = 5'd15 - {1'b0, attack_rate};
            ST_DECAY:   w_period_m1 = 5'd7 - {2'b00, decay_rate};
            ST_SUSTAIN: w_period_m1 = 5'd31 - sustain_rate;
            default:    w_period_m1 = 5'd0;
        endcase
    end

    assign w_fire   = (r_cnt == w_period_m1);
    assign w_prod1  = sample_in * w_env_s;
    assign w_prod_l = r_s1 * volume_left;
    assign w_prod_r = r_s1 * volume_right;

    function automatic logic signed [15:0] scale_out(input logic signed [23:0] p);
`ifdef DSP_ENV_SATURATE_EN
        if (p[23:21] != {3{p[23]}})
            return p[23] ? 16'sh8000 : 16'sh7FFF;
        return 16'(p >>> 6);
`else
        return 16'(p >>> 6);
`endif
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_env   <= 11'd0;
            r_cnt   <= 5'd0;
            r_v1    <= 1'b0;
            r_s1    <= 16'sd0;
            r_out_l <= 16'sd0;
            r_out_r <= 16'sd0;
            r_out_v <= 1'b0;
        end else begin
            // Gain stage uses the envelope as it stood before this tick's step.
            r_v1    <= sample_tick;
            r_out_v <= r_v1;
            if (sample_tick)
                r_s1 <= 16'(w_prod1 >>> 11);
            if (r_v1) begin
                r_out_l <= scale_out(w_prod_l);
                r_out_r <= scale_out(w_prod_r);
            end

            if (key_on) begin
                r_env   <= 11'd0;
                r_state <= ST_ATTACK;
                r_cnt   <= 5'd0;
            end else if (voice_end && r_state != ST_IDLE) begin
                r_env   <= 11'd0;
                r_state <= ST_IDLE;
                r_cnt   <= 5'd0;
            end else if (key_off && (r_state == ST_ATTACK || r_state == ST_DECAY ||
                                     r_state == ST_SUSTAIN)) begin
                r_state <= ST_RELEASE;
                r_cnt   <= 5'd0;
            end else if (sample_tick) begin
                case (r_state)
                    ST_ATTACK: begin
                        if (w_fire) begin
                            r_cnt <= 5'd0;
                            if (w_att_sum >= 12'h7E0) begin
                                r_env   <= ENV_MAX;
                                r_state <= ST_DECAY;
                            end else begin
                                r_env <= w_att_sum[10:0];
                            end
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                    ST_DECAY: begin
                        if (w_fire) begin
                            r_cnt <= 5'd0;
                            r_env <= w_exp_env;
                            if ({1'b0, w_exp_env} <= w_sus_thr)
                                r_state <= ST_SUSTAIN;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                    ST_SUSTAIN: begin
                        if (sustain_rate == 5'd0) begin
                            r_cnt <= 5'd0;
                        end else if (w_fire) begin
                            r_cnt <= 5'd0;
                            r_env <= w_exp_env;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                    ST_RELEASE: begin
                        if (w_rel_res <= 12'sd0) begin
                            r_env   <= 11'd0;
                            r_state <= ST_IDLE;
                            r_cnt   <= 5'd0;
                        end else begin
                            r_env <= w_rel_res[10:0];
                        end
                    end
                    default: begin
                        r_env <= 11'd0;
                        r_cnt <= 5'd0;
                    end
                endcase
            end
        end
    end

    assign out_left  = r_out_l;
    assign out_right = r_out_r;
    assign out_valid = r_out_v;
    assign envelope  = r_env;
    assign env_state = r_state;

endmodule
